// File: rtl/trail_stack.sv
// Assignment trail for the SAT datapath: records decisions/implications, unwinds on conflict
// and flips the most recent unflipped decision. One pop per cycle; all outputs registered.
`ifndef MAX_VARS
`define MAX_VARS 8
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module trail_stack #(
    parameter int DEPTH    = `MAX_VARS,
    parameter int IDX_BITS = `MAX_VARS_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [IDX_BITS-1:0] push_var,
    input  logic                push_val,
    input  logic                push_is_dec,
    input  logic [IDX_BITS-1:0] push_dec_idx,
    input  logic                conflict,
    output logic                busy,
    output logic                unassign_valid,
    output logic [IDX_BITS-1:0] unassign_var,
    output logic                bt_done,
    output logic [IDX_BITS-1:0] bt_var,
    output logic                bt_val,
    output logic [IDX_BITS-1:0] bt_next_dec_idx,
    output logic                unsat,
    output logic                overflow,
    output logic [IDX_BITS:0]   count,
    output logic                full,
    output logic                empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_BITS:0] DEPTH_C = (IDX_BITS+1)'(DEPTH);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_POP  = 1'b1;

    logic [IDX_BITS-1:0] ent_var_q  [DEPTH];
    logic                ent_val_q  [DEPTH];
    logic                ent_dec_q  [DEPTH];
    logic [IDX_BITS-1:0] ent_didx_q [DEPTH];

    logic [0:0]          state_q, state_d;
    logic [IDX_BITS:0]   count_q, count_d;
    logic                busy_q, full_q, empty_q;
    logic                unassign_valid_q, unassign_valid_d;
    logic [IDX_BITS-1:0] unassign_var_q, unassign_var_d;
    logic                bt_done_q, bt_done_d;
    logic [IDX_BITS-1:0] bt_var_q, bt_var_d;
    logic                bt_val_q, bt_val_d;
    logic [IDX_BITS-1:0] bt_next_q, bt_next_d;
    logic                unsat_q, unsat_d;
    logic                overflow_q, overflow_d;
    logic                wr_en, flip_en;
    logic [AW-1:0]       wr_ptr, top_ptr;

    assign wr_ptr  = AW'(count_q);
    assign top_ptr = AW'(count_q - 1'b1);

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        unassign_valid_d = 1'b0;
        unassign_var_d   = unassign_var_q;
        bt_done_d        = 1'b0;
        bt_var_d         = bt_var_q;
        bt_val_d         = bt_val_q;
        bt_next_d        = bt_next_q;
        unsat_d          = unsat_q;
        overflow_d       = overflow_q;
        wr_en            = 1'b0;
        flip_en          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A push in the conflict cycle lands first, so it is unwound too.
                if (!unsat_q) begin
                    if (push) begin
                        if (full_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (conflict) state_d = ST_POP;
                end
            end
            ST_POP: begin
                if (empty_q) begin
                    unsat_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (ent_dec_q[top_ptr]) begin
                    flip_en   = 1'b1;
                    bt_done_d = 1'b1;
                    bt_var_d  = ent_var_q[top_ptr];
                    bt_val_d  = ~ent_val_q[top_ptr];
                    bt_next_d = ent_didx_q[top_ptr] + 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    count_d          = count_q - 1'b1;
                    unassign_valid_d = 1'b1;
                    unassign_var_d   = ent_var_q[top_ptr];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry storage needs no reset: count gates which slots are meaningful.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            ent_var_q[wr_ptr]  <= push_var;
            ent_val_q[wr_ptr]  <= push_val;
            ent_dec_q[wr_ptr]  <= push_is_dec;
            ent_didx_q[wr_ptr] <= push_dec_idx;
        end else if (!reset && flip_en) begin
            ent_val_q[top_ptr] <= ~ent_val_q[top_ptr];
            ent_dec_q[top_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            count_q          <= '0;
            busy_q           <= 1'b0;
            full_q           <= 1'b0;
            empty_q          <= 1'b1;
            unassign_valid_q <= 1'b0;
            unassign_var_q   <= '0;
            bt_done_q        <= 1'b0;
            bt_var_q         <= '0;
            bt_val_q         <= 1'b0;
            bt_next_q        <= '0;
            unsat_q          <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            busy_q           <= (state_d == ST_POP);
            full_q           <= (count_d == DEPTH_C);
            empty_q          <= (count_d == '0);
            unassign_valid_q <= unassign_valid_d;
            unassign_var_q   <= unassign_var_d;
            bt_done_q        <= bt_done_d;
            bt_var_q         <= bt_var_d;
            bt_val_q         <= bt_val_d;
            bt_next_q        <= bt_next_d;
            unsat_q          <= unsat_d;
            overflow_q       <= overflow_d;
        end
    end

    assign busy            = busy_q;
    assign unassign_valid  = unassign_valid_q;
    assign unassign_var    = unassign_var_q;
    assign bt_done         = bt_done_q;
    assign bt_var          = bt_var_q;
    assign bt_val          = bt_val_q;
    assign bt_next_dec_idx = bt_next_q;
    assign unsat           = unsat_q;
    assign overflow        = overflow_q;
    assign count           = count_q;
    assign full            = full_q;
    assign empty           = empty_q;

endmodule

// File: tb/tb_trail_stack.sv
// Bench for trail_stack: directed vector table, hand-written corner sequences,
// and a random run compared against a queue-based model of the trail.
module tb_trail_stack;

    localparam int DEPTH = 8;
    localparam int IB    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [IB-1:0] push_var;
    logic          push_val;
    logic          push_is_dec;
    logic [IB-1:0] push_dec_idx;
    logic          conflict;
    logic          busy, unassign_valid, bt_done, bt_val, unsat, overflow, full, empty;
    logic [IB-1:0] unassign_var, bt_var, bt_next_dec_idx;
    logic [IB:0]   count;

    int checks = 0;
    int errors = 0;

    trail_stack #(.DEPTH(DEPTH), .IDX_BITS(IB)) dut (
        .clock(clk), .reset(rst), .push(push), .push_var(push_var), .push_val(push_val),
        .push_is_dec(push_is_dec), .push_dec_idx(push_dec_idx), .conflict(conflict),
        .busy(busy), .unassign_valid(unassign_valid), .unassign_var(unassign_var),
        .bt_done(bt_done), .bt_var(bt_var), .bt_val(bt_val), .bt_next_dec_idx(bt_next_dec_idx),
        .unsat(unsat), .overflow(overflow), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int push, pvar, pval, pdec, pdidx, conf;
        int cnt, busy, uv, uvar, bd, btvar, btval, btn, unsat;
    } vec_t;

    typedef struct {
        int v, val, dec, didx;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    int m_busy, m_unsat, m_ovf, m_uv, m_uvar, m_bd, m_btvar, m_btval, m_btn;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input int v, input int val, input int dec,
                         input int didx, input int c, input int r);
        push         = (p != 0);
        push_var     = IB'(v);
        push_val     = (val != 0);
        push_is_dec  = (dec != 0);
        push_dec_idx = IB'(didx);
        conflict     = (c != 0);
        rst          = (r != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int cnt, input int bsy, input int uv,
                             input int uvar, input int bd, input int btv, input int btl,
                             input int btn, input int uns, input int ovf);
        chk({tag, ".count"}, int'(count), cnt);
        chk({tag, ".full"}, int'(full), int'(cnt == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(cnt == 0));
        chk({tag, ".busy"}, int'(busy), bsy);
        chk({tag, ".unassign_valid"}, int'(unassign_valid), uv);
        chk({tag, ".unassign_var"}, int'(unassign_var), uvar);
        chk({tag, ".bt_done"}, int'(bt_done), bd);
        chk({tag, ".bt_var"}, int'(bt_var), btv);
        chk({tag, ".bt_val"}, int'(bt_val), btl);
        chk({tag, ".bt_next_dec_idx"}, int'(bt_next_dec_idx), btn);
        chk({tag, ".unsat"}, int'(unsat), uns);
        chk({tag, ".overflow"}, int'(overflow), ovf);
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_unsat = 0; m_ovf = 0; m_uv = 0; m_uvar = 0;
        m_bd = 0; m_btvar = 0; m_btval = 0; m_btn = 0;
    endtask

    // One clock of the trail's behaviour, described as stack operations.
    task automatic model_step(input int p, input int v, input int val, input int dec,
                              input int didx, input int c, input int r);
        ent_t e;
        if (r != 0) begin
            model_reset();
            return;
        end
        m_uv = 0;
        m_bd = 0;
        if (m_busy == 0) begin
            if (m_unsat == 0) begin
                if (p != 0) begin
                    if (mq.size() == DEPTH) m_ovf = 1;
                    else mq.push_back('{v, val, dec, didx});
                end
                if (c != 0) m_busy = 1;
            end
        end else if (mq.size() == 0) begin
            m_unsat = 1;
            m_busy  = 0;
        end else if (mq[$].dec != 0) begin
            e       = mq[$];
            e.val   = 1 - e.val;
            e.dec   = 0;
            mq[$]   = e;
            m_bd    = 1;
            m_btvar = e.v;
            m_btval = e.val;
            m_btn   = (e.didx + 1) % (1 << IB);
            m_busy  = 0;
        end else begin
            m_uv   = 1;
            m_uvar = mq[$].v;
            mq.pop_back();
        end
    endtask

    vec_t tbl[12];

    initial begin
        // push dec var3/0/idx2, impl var5=1, var7=0, conflict, unwind, flip,
        // second conflict down to unsat, then ignored push+conflict
        tbl[0]  = '{1, 3, 0, 1, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5, 1, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 7, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0,  2, 1, 1, 7, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,  1, 1, 1, 5, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 5, 1, 3, 1, 3, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1,  1, 1, 0, 5, 0, 3, 1, 3, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,  0, 1, 1, 3, 0, 3, 1, 3, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 3, 1, 3, 1};
        tbl[10] = '{1, 2, 1, 1, 4, 1,  0, 0, 0, 3, 0, 3, 1, 3, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 3, 1, 3, 1};

        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].push, tbl[i].pvar, tbl[i].pval, tbl[i].pdec, tbl[i].pdidx, tbl[i].conf, 0);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].busy, tbl[i].uv, tbl[i].uvar,
                      tbl[i].bd, tbl[i].btvar, tbl[i].btval, tbl[i].btn, tbl[i].unsat, 0);
        end

        // Fill to capacity, then one push too many
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, i, i % 2, 0, 0, 0, 0);
            step();
        end
        chk("fill.count", int'(count), 8);
        chk("fill.full", int'(full), 1);
        chk("fill.overflow_before", int'(overflow), 0);
        drive(1, 9, 1, 1, 0, 0, 0);
        step();
        chk("ovf.count", int'(count), 8);
        chk("ovf.overflow", int'(overflow), 1);
        chk("ovf.full", int'(full), 1);

        // Push in the same cycle as conflict joins the unwind
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 1, 0, 1, 0, 0, 0);
        step();
        drive(1, 4, 1, 0, 0, 1, 0);
        step();
        chk("pc.count", int'(count), 2);
        chk("pc.busy", int'(busy), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("pc.uv", int'(unassign_valid), 1);
        chk("pc.uvar", int'(unassign_var), 4);
        step();
        chk("pc.bt_done", int'(bt_done), 1);
        chk("pc.bt_var", int'(bt_var), 1);
        chk("pc.bt_val", int'(bt_val), 1);
        chk("pc.bt_next", int'(bt_next_dec_idx), 1);
        chk("pc.busy_end", int'(busy), 0);
        chk("pc.count_end", int'(count), 1);

        // Reset in the middle of an unwind
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 2, 1, 1, 6, 0, 0);
        step();
        for (int i = 3; i <= 5; i++) begin
            drive(1, i, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mr.uv", int'(unassign_valid), 1);
        chk("mr.uvar", int'(unassign_var), 5);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        check_all("mr.after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mr.no_bt", int'(bt_done), 0);
        chk("mr.idle_count", int'(count), 0);

        // Random traffic against the queue model
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int p, v, val, dec, didx, c, r;
            p    = ($urandom_range(0, 99) < 55) ? 1 : 0;
            v    = $urandom_range(0, 15);
            val  = $urandom_range(0, 1);
            dec  = ($urandom_range(0, 99) < 30) ? 1 : 0;
            didx = $urandom_range(0, 15);
            c    = ($urandom_range(0, 99) < 12) ? 1 : 0;
            r    = ($urandom_range(0, 99) < 2) ? 1 : 0;
            drive(p, v, val, dec, didx, c, r);
            model_step(p, v, val, dec, didx, c, r);
            step();
            check_all($sformatf("rnd%0d", cyc), mq.size(), m_busy, m_uv, m_uvar, m_bd,
                      m_btvar, m_btval, m_btn, m_unsat, m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trail_stack.md
# trail_stack

Assignment trail for the SAT solver datapath, sitting directly downstream of `decider`. It records every variable assignment in order: decisions from the decider and implications from propagation. On a conflict it unwinds the trail one entry per cycle, emitting variable unassignments. It then flips the most recent unflipped decision and produces the resume index that the control unit writes into the decider's `back_dec_idx`. A conflict with no flippable decision left raises `unsat`.

## Interface
Parameters:
- `DEPTH`, default `` `MAX_VARS ``: trail entries (one per variable max)
- `IDX_BITS`, default `` `MAX_VARS_BITS ``: width of variable and decision indices

Ports:
- `clock`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `push`  in  1  record one assignment this cycle
- `push_var`  in  IDX_BITS  variable index
- `push_val`  in  1  assigned value
- `push_is_dec`  in  1  1 = decision (from decider), 0 = implication
- `push_dec_idx`  in  IDX_BITS  decider `dec_idx_out` for this decision; don't-care when `push_is_dec`=0
- `conflict`  in  1  start backtrack
- `busy`  out  1  backtrack in progress
- `unassign_valid`  out  1  one-cycle pulse per popped entry
- `unassign_var`  out  IDX_BITS  variable to clear
- `bt_done`  out  1  one-cycle pulse: decision flipped
- `bt_var`  out  IDX_BITS  flipped variable
- `bt_val`  out  1  its new (inverted) value
- `bt_next_dec_idx`  out  IDX_BITS  stored dec_idx + 1, truncated to IDX_BITS
- `unsat`  out  1  sticky until reset
- `overflow`  out  1  sticky: push attempted while full
- `count`  out  IDX_BITS+1  valid entries
- `full`, `empty`  out  1  count==DEPTH / count==0

## Operation
- Entry fields: var, val, is_dec, dec_idx. Storage is a register array indexed by `count`. Top entry = index count-1.
- FSM states:
  - IDLE: accepts push and conflict.
  - POP: unwinds the trail.
- IDLE, `push`=1, not full: write entry at index count, count+1.
- IDLE, `push`=1, full: entry dropped, count unchanged, `overflow`<=1.
- IDLE, `conflict`=1: go to POP. If `push`=1 in the same cycle, the push is recorded first, so the new entry is part of the unwind.
- POP, each cycle, exactly one of:
  - count==0: `unsat`<=1, go to IDLE.
  - top is_dec=1: flip in place (val inverted, is_dec<=0, count unchanged). Load `bt_var`/`bt_val`/`bt_next_dec_idx`, pulse `bt_done`, go to IDLE.
  - top is_dec=0: count-1, pulse `unassign_valid` with `unassign_var`=top var.
- A flipped entry is an implication, so a later conflict pops past it.
- `push` and `conflict` are ignored while `busy`=1 or `unsat`=1.
- The block never re-pushes; the flipped variable stays assigned with its new value.

## Timing
- All outputs are registered.
- Reset values: `busy`, `unassign_valid`, `bt_done`, `unsat`, `overflow` = 0; `count`=0, `empty`=1, `full`=0; `unassign_var`, `bt_var`, `bt_val`, `bt_next_dec_idx` = 0. State = IDLE.
- `count`/`full`/`empty` reflect a push on the edge after it is sampled.
- Conflict sampled at edge E0 with k implications above the nearest decision:
  - `busy`=1 from E0.
  - `unassign_valid` pulses after edges E1..Ek, one per cycle, in top-down order.
  - `bt_done` is high for the single cycle after E(k+1); `busy` is 0 in that same cycle.
- No decision on the trail: k unassign pulses, then `unsat`=1 and `busy`=0 after E(k+1).
- `bt_*` and `unassign_var` hold their last values between pulses.
- Reset mid-POP: after the edge, state IDLE, count 0, all pulses 0, sticky flags cleared.
- Reset has priority over push and conflict.

## Test plan
DEPTH=8, IDX_BITS=4.
1. Reset -> count=0, empty=1, full=0, busy=0, unsat=0, overflow=0, no pulses.
2. Push dec (var3, val0, dec_idx2), impl var5=1, impl var7=0, then conflict -> unassign_var 7, then 5 on consecutive cycles; next cycle bt_done=1, bt_var=3, bt_val=1, bt_next_dec_idx=3; count=1.
3. Continue from 2, conflict again -> unassign_var 3, next cycle unsat=1, count=0; later push/conflict ignored.
4. Push 8 entries -> full=1; 9th push -> count stays 8, overflow=1.
5. Push dec var1 (dec_idx0), then push impl var4 in the same cycle as conflict -> unassign 4, then bt_done with bt_var=1, bt_next_dec_idx=1.
6. Three implications above a decision; conflict; assert reset after the first unassign pulse -> next cycle count=0, busy=0, no bt_done.
